// File: rtl/lsu_mem_access_pkg.sv
// rtl/lsu_mem_access_pkg.sv - shared encodings and store formatting helpers for the LSU
package lsu_mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; alignment is checked per access size.
  function automatic logic is_legal(input logic is_store, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_mem_access_load_align.sv
// rtl/lsu_mem_access_load_align.sv - picks the load lane from a word and sign/zero-extends it
module lsu_load_align
  import lsu_mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_data = i_word;
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - RV32I load/store unit driving a single-outstanding req/ack memory port
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int BITS             = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [BITS-1:0] addr,
  input  logic [BITS-1:0] wdata,
  output logic [BITS-1:0] rdata,
  output logic            stall,
  output logic            err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BITS-3:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [BITS-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [BITS-1:0] mem_rdata
);

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic [1:0]      r_off;
  logic [2:0]      r_f3;
  logic [BITS-1:0] r_rdata;
  logic            r_err;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [BITS-3:0] r_mem_addr;
  logic [3:0]      r_mem_be;
  logic [BITS-1:0] r_mem_wdata;

  logic            w_access;
  logic            w_store;
  logic            w_legal;
  logic [BITS-1:0] w_load;

  assign w_access = MemRead | MemWrite;
  assign w_store  = MemWrite;
  assign w_legal  = is_legal(w_store, Funct3, addr[1:0]);

  lsu_load_align u_align (
    .i_word   (mem_rdata),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  // Inputs are only examined in IDLE, so DONE releases the pipeline without re-triggering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_off       <= 2'd0;
      r_f3        <= 3'd0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            if (w_legal) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_store;
              r_mem_addr  <= addr[BITS-1:2];
              r_mem_be    <= w_store ? store_be(Funct3, addr[1:0]) : 4'b1111;
              r_mem_wdata <= w_store ? store_data(Funct3, wdata) : '0;
              r_off       <= addr[1:0];
              r_f3        <= Funct3;
              r_cnt       <= 8'd0;
              r_state     <= ST_REQ;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= r_mem_we ? '0 : w_load;
            r_state   <= ST_DONE;
          end else if (r_cnt == 8'(TIMEOUT - 1)) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_rdata   <= '0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = (r_state == ST_REQ) || ((r_state == ST_IDLE) && w_access && w_legal);
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - scoreboard bench for lsu_mem_access with directed load/store vectors
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  lsu_mem_access #(.BITS(32), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Funct3    (Funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic        e;
    logic        chk_rd;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_stall = 1'b0;
  logic prev_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: request launches and completion/err events are matched against the queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_req   = 1'b0;
    end else begin
      if (mem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, r.we});
          chk("mem_addr", {2'd0, mem_addr}, {2'd0, r.waddr});
          chk("mem_be", {28'd0, mem_be}, {28'd0, r.be});
          chk("mem_wdata", mem_wdata, r.wd);
        end
      end
      if ((prev_stall && !stall) || err) begin
        if (rsp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_rsp: got err %b rdata %h expected none", err, rdata);
        end else begin
          rsp_t s;
          s = rsp_q.pop_front();
          chk("err", {31'd0, err}, {31'd0, s.e});
          if (s.chk_rd) chk("rdata", rdata, s.rd);
        end
      end
      prev_stall = stall;
      prev_req   = mem_req;
    end
  end

  // k = cycle (relative to issue) in which mem_ack is pulsed; 0 means never.
  task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input int k,
                     input logic [31:0] word, input int exp_stall, input int exp_req);
    int   n_st;
    int   n_rq;
    logic st_now;
    n_st = 0;
    n_rq = 0;
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40; c++) begin
      if (k > 0 && c == k) begin
        mem_ack = 1'b1; mem_rdata = word;
      end
      @(negedge clk);
      st_now = stall;
      if (stall) n_st++;
      if (mem_req) n_rq++;
      @(posedge clk); #1;
      mem_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      if (!st_now) break;
    end
    chk({name, "_stall_cycles"}, 32'(n_st), 32'(exp_stall));
    chk({name, "_req_cycles"}, 32'(n_rq), 32'(exp_req));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {2'd0, mem_addr}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b1});
    run("lw", 1, 0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF, 4, 3);

    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'hFFFFFF80, 1'b0, 1'b1});
    run("lb", 1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF0000, 2, 1);

    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'h00000080, 1'b0, 1'b1});
    run("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF0000, 2, 1);

    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'hFFFF8001, 1'b0, 1'b1});
    run("lh", 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80011234, 3, 2);

    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'h00001234, 1'b0, 1'b1});
    run("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 1, 32'h80011234, 2, 1);

    req_q.push_back('{1'b1, 30'h08, 4'b1100, 32'hABCDABCD});
    rsp_q.push_back('{32'h0, 1'b0, 1'b0});
    run("sh", 0, 1, 3'b001, 32'h22, 32'h1234ABCD, 2, 32'h0, 3, 2);

    req_q.push_back('{1'b1, 30'h00, 4'b0010, 32'h55555555});
    rsp_q.push_back('{32'h0, 1'b0, 1'b0});
    run("sb", 0, 1, 3'b000, 32'h01, 32'h00000055, 1, 32'h0, 2, 1);

    // Both controls set: must behave as a store.
    req_q.push_back('{1'b1, 30'h04, 4'b1111, 32'hCAFEF00D});
    rsp_q.push_back('{32'h0, 1'b0, 1'b0});
    run("sw_both", 1, 1, 3'b010, 32'h10, 32'hCAFEF00D, 1, 32'h0, 2, 1);

    rsp_q.push_back('{32'h0, 1'b1, 1'b1});
    run("lw_misalign", 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 0, 0);
    rsp_q.push_back('{32'h0, 1'b1, 1'b1});
    run("lh_misalign", 1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 0, 0);
    rsp_q.push_back('{32'h0, 1'b1, 1'b1});
    run("load_f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 0, 0);
    rsp_q.push_back('{32'h0, 1'b1, 1'b1});
    run("store_f3_100", 0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 0, 0);

    // Load a nonzero value first so the timeout's rdata=0 is observable.
    req_q.push_back('{1'b0, 30'h40, 4'b1111, 32'h0});
    rsp_q.push_back('{32'h11223344, 1'b0, 1'b1});
    run("lw2", 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'h11223344, 2, 1);

    req_q.push_back('{1'b1, 30'h08, 4'b1111, 32'h0BADF00D});
    rsp_q.push_back('{32'h0, 1'b1, 1'b1});
    run("sw_timeout", 0, 1, 3'b010, 32'h20, 32'h0BADF00D, 0, 32'h0, 5, 4);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_ack_stall", {31'd0, stall}, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", rdata, 32'd0);

    // Reset in the middle of an outstanding load.
    @(posedge clk); #1;
    req_q.push_back('{1'b0, 30'h80, 4'b1111, 32'h0});
    MemRead = 1'b1; Funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1 MemRead = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    req_q.push_back('{1'b0, 30'h80, 4'b1111, 32'h0});
    rsp_q.push_back('{32'h600DCAFE, 1'b0, 1'b1});
    run("lw_after_rst", 1, 0, 3'b010, 32'h200, 32'h0, 2, 32'h600DCAFE, 3, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
